// File: rtl/adders_pkg.sv
// Shared definitions for the adder family: state encoding for the serial
// adder FSM and a helper that sizes its bit counter.
package adders_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } sa_state_t;

  // Counter must hold values 0..width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bundle for the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell reused every cycle by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the
// operands LSB first, one bit per clock, under a start/busy/done handshake.
module serial_adder
  import adders_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             fa_s;
  logic             fa_c;
  logic             accept;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // A new operation may begin from IDLE or straight out of DONE; start is
  // deliberately ignored while shifting.
  assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        carry  <= bus.cin;
        cnt    <= '0;
        sum_r  <= '0;
        cout_r <= 1'b0;
        busy_r <= 1'b1;
        state  <= ST_SHIFT;
      end else begin
        case (state)
          ST_SHIFT: begin
            // New sum bit enters at the MSB so the LSB lands at bit 0 last.
            sum_r <= (sum_r >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= fa_c;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              cout_r <= fa_c;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= ST_DONE;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          default: begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 against an
// arithmetic reference model.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one WIDTH=8 addition starting at a negedge; optionally re-pulses
  // start with junk operands during SHIFT cycle repulseAt.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic cv, input int repulseAt);
    logic [8:0] expected;
    expected = 9'(av) + 9'(bv) + 9'(cv);
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.cin   = cv;
    stepCycle();
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      checkOutput("busy8_shift", 32'(bus8.busy), 32'd1);
      checkOutput("done8_shift", 32'(bus8.done), 32'd0);
      bus8.start = (i == repulseAt);
      stepCycle();
    end
    bus8.start = 1'b0;
    checkOutput("done8_pulse", 32'(bus8.done), 32'd1);
    checkOutput("busy8_done",  32'(bus8.busy), 32'd0);
    checkOutput("result8",     32'({bus8.cout, bus8.sum}), 32'(expected));
  endtask

  task automatic idleCycle8(input logic [8:0] held);
    bus8.start = 1'b0;
    stepCycle();
    checkOutput("done8_idle", 32'(bus8.done), 32'd0);
    checkOutput("busy8_idle", 32'(bus8.busy), 32'd0);
    checkOutput("hold8",      32'({bus8.cout, bus8.sum}), 32'(held));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] last;
    vectors     = 0;
    miscompares = 0;
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    bus1.cin   = 1'b0;

    @(negedge clk);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    checkOutput("reset_busy", 32'(bus8.busy), 32'd0);
    checkOutput("reset_done", 32'(bus8.done), 32'd0);
    checkOutput("reset_sum",  32'(bus8.sum),  32'd0);
    checkOutput("reset_cout", 32'(bus8.cout), 32'd0);
    checkOutput("reset_done1", 32'(bus1.done), 32'd0);

    $display("[TB] directed WIDTH=8 additions");
    applyStimulus(8'hFF, 8'h01, 1'b0, -1);
    checkOutput("ff01_sum",  32'(bus8.sum),  32'h00);
    checkOutput("ff01_cout", 32'(bus8.cout), 32'd1);
    idleCycle8(9'h100);
    applyStimulus(8'hA5, 8'h5A, 1'b1, -1);
    checkOutput("a55a_sum",  32'(bus8.sum),  32'h00);
    checkOutput("a55a_cout", 32'(bus8.cout), 32'd1);
    idleCycle8(9'h100);
    applyStimulus(8'h3C, 8'h42, 1'b0, -1);
    checkOutput("3c42_sum",  32'(bus8.sum),  32'h7E);
    checkOutput("3c42_cout", 32'(bus8.cout), 32'd0);
    idleCycle8(9'h07E);

    $display("[TB] start ignored during SHIFT, then back-to-back");
    applyStimulus(8'h12, 8'h34, 1'b1, 3);
    applyStimulus(8'hC8, 8'h77, 1'b1, 7);
    applyStimulus(8'h80, 8'h80, 1'b0, -1);
    idleCycle8(9'h100);

    $display("[TB] random WIDTH=8 additions");
    for (int k = 0; k < 12; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      last = 9'(ra) + 9'(rb) + 9'(rc);
      applyStimulus(ra, rb, rc, int'($urandom_range(0, 9)) - 1);
      if (k % 3 == 0) idleCycle8(last);
    end
    idleCycle8(last);

    $display("[TB] reset during SHIFT");
    bus8.start = 1'b1;
    bus8.a     = 8'hFF;
    bus8.b     = 8'hFF;
    bus8.cin   = 1'b1;
    stepCycle();
    bus8.start = 1'b0;
    stepCycle();
    stepCycle();
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rst_mid_busy", 32'(bus8.busy), 32'd0);
    checkOutput("rst_mid_sum",  32'(bus8.sum),  32'd0);
    checkOutput("rst_mid_cout", 32'(bus8.cout), 32'd0);
    for (int i = 0; i < 12; i++) begin
      checkOutput("rst_mid_nodone", 32'(bus8.done), 32'd0);
      stepCycle();
    end

    $display("[TB] exhaustive WIDTH=1");
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      logic [1:0] exp1;
      bits = 3'(v);
      exp1 = 2'(bits[0]) + 2'(bits[1]) + 2'(bits[2]);
      bus1.a     = bits[0];
      bus1.b     = bits[1];
      bus1.cin   = bits[2];
      bus1.start = 1'b1;
      stepCycle();
      bus1.start = 1'b0;
      bus1.a     = ~bits[0];
      bus1.b     = ~bits[1];
      checkOutput("w1_busy", 32'(bus1.busy), 32'd1);
      checkOutput("w1_done_early", 32'(bus1.done), 32'd0);
      stepCycle();
      checkOutput("w1_done", 32'(bus1.done), 32'd1);
      checkOutput("w1_result", 32'({bus1.cout, bus1.sum}), 32'(exp1));
      stepCycle();
      checkOutput("w1_done_clear", 32'(bus1.done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
